fetch_scheduler: RTL and testbench
==================================

Name: fetch_scheduler

Overview:
Instruction-fetch sequencer for the LEGv8 pipeline. Owns the PC, drives the 6-bit word address of the combinational instruction ROM and issues instructions to decode. Detects RAW hazards against recently issued register writes and inserts NOP bubbles (32'hd503201f) in hardware, so programs no longer need hand-placed NOPs. Handles taken-branch redirects, downstream stalls and end-of-program halt.

Parameters:
- ROM_WORDS, 23, number of valid ROM words; fetching PC/4 >= ROM_WORDS halts.
- HAZ_DEPTH, 3, number of issue slots a written register stays unreadable (no forwarding in the datapath).
- CNT_W, 16, width of the bubble statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins fetching at PC 0.
- imem_addr  out  6  word address = pc[7:2].
- imem_q  in  32  ROM data for imem_addr, same cycle (combinational ROM).
- id_ready  in  1  decode accepts this cycle; low = hold.
- if_valid  out  1  issue-slot valid, registered.
- if_instr  out  32  issued instruction or NOP, registered.
- if_pc  out  64  PC of the issued slot, registered.
- br_taken  in  1  taken branch resolved in MEM this cycle.
- br_target  in  64  branch target byte address.
- done  out  1  high in DONE state.
- bubble_cnt  out  CNT_W  number of hazard bubbles inserted since reset; saturates.

Behaviour:
- Reset values: pc=0, state=IDLE, if_valid=0, if_instr=NOP, if_pc=0, done=0, bubble_cnt=0, scoreboard all invalid. Reset asserted mid-run overrides everything in the same edge.
- States:
  - IDLE: start -> RUN.
  - RUN: pc/4 >= ROM_WORDS -> DONE.
  - DONE: br_taken -> RUN.
- In IDLE and DONE: if_valid=0 and if_instr=NOP. The scoreboard still shifts in invalid entries each cycle.
- Instruction decode of imem_q:
  - Writers (rd=[4:0]): R-type ADD/SUB/AND/ORR (opcode[31:21] = 458/658/450/550), ADDI/SUBI ([31:22] = 244/344), LDUR ([31:21] = 7C2).
  - Register readers:
    - R-type reads [9:5] and [20:16].
    - ADDI/SUBI/LDUR read [9:5].
    - STUR (7C0) reads [9:5] and [4:0].
    - CBZ/CBNZ ([31:24] = B4/B5) read [4:0].
    - B, NOP and unknown opcodes read nothing.
  - Register 31 (XZR) never causes a hazard and is never recorded.
- Scoreboard: HAZ_DEPTH-entry shift register of {valid, rd[4:0]}. It shifts once per advancing slot (issue or bubble). A hazard exists when any valid entry matches any source read by imem_q.
- RUN cycle with id_ready=1 and br_taken=0:
  - Hazard: emit if_instr=NOP, if_valid=1, if_pc=pc. pc holds, shift in invalid, bubble_cnt+1.
  - No hazard: emit imem_q, if_valid=1, if_pc=pc. pc+=4, shift in {writes, rd}.
- id_ready=0 and br_taken=0: all registers hold (outputs, pc, scoreboard, counter).
- br_taken=1, which has priority over id_ready, hazard and state:
  - pc<=br_target; emit NOP with if_valid=0.
  - Shift in invalid; the scoreboard is not cleared. This is conservative, because older writers are still in flight.
  - State -> RUN, or -> DONE next cycle if the target is out of range.
- Issue latency: one cycle from imem_addr to the registered if_instr.
- Width rules: pc is 64-bit and wraps modulo 2^64. imem_addr ignores pc[1:0] and pc[63:8]. bubble_cnt saturates at all-ones.

Decomposition:
- Shared package legv8_pkg:
  - NOP_INSTR constant.
  - Opcode constants.
  - Instruction-class enum.
  - fsm state enum {IDLE, RUN, DONE}.
  - Scoreboard entry struct.
- One sub-module, instr_regdecode: combinational; from a 32-bit instruction it gives writes, rd, rn_used, rn, rm_used, rm.

Test Plan:
- Reset, then start, with ROM words 0=8b1f03e0 and 1=91002001 -> issue 8b1f03e0 at pc 0, then 3 NOP bubbles at if_pc=4, then 91002001. bubble_cnt=3.
- Program 8b000001 then 8b010021 (X1 written, then read) -> 3 bubbles between them. With 2 hand NOPs in between -> exactly 1 bubble.
- Writer to X31 (8b1f03ff) then a reader of X31 -> 0 bubbles.
- Hold id_ready=0 for 5 cycles mid-program -> if_instr, if_pc, pc and bubble_cnt unchanged. Resume -> sequence continues identically.
- br_taken=1 with br_target=0x40 while a hazard is pending -> next slot has if_valid=0. Following fetch uses imem_addr=16. Scoreboard entries still block a dependent read at the target.
- Run past word 22 -> done=1, if_valid=0. Then br_taken with target 0 -> RUN, fetch 8b1f03e0. Assert reset mid-run -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 fetch front end.
// Holds the NOP encoding, the opcode fields that the register decoder
// recognises, the instruction-class, FSM-state and per-cycle-action enums,
// the hazard scoreboard entry, and a classify() helper used by the decoder.
package legv8_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hd503201f;
  localparam logic [4:0]  XZR       = 5'd31;

  // R-type and D-type opcodes live in [31:21]
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  // I-type opcodes live in [31:22]
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  // CB-type opcodes live in [31:24]
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;

  typedef enum logic [2:0] {
    IC_RTYPE, IC_IMM, IC_LOAD, IC_STORE, IC_CBR, IC_OTHER
  } iclass_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // What the datapath does on the coming edge
  typedef enum logic [2:0] {
    A_HOLD,    // decode stalled: freeze everything
    A_IDLE,    // no slot: emit invalid NOP, age the scoreboard
    A_REDIR,   // taken branch: load target, squash the slot
    A_BUBBLE,  // RAW hazard: emit valid NOP, pc holds
    A_ISSUE    // issue imem_q, advance pc
  } act_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic iclass_e classify(input logic [31:0] i);
    iclass_e c;
    if (i[31:21] == OP_ADD || i[31:21] == OP_SUB ||
        i[31:21] == OP_AND || i[31:21] == OP_ORR)     c = IC_RTYPE;
    else if (i[31:22] == OP_ADDI || i[31:22] == OP_SUBI) c = IC_IMM;
    else if (i[31:21] == OP_LDUR)                     c = IC_LOAD;
    else if (i[31:21] == OP_STUR)                     c = IC_STORE;
    else if (i[31:24] == OP_CBZ || i[31:24] == OP_CBNZ) c = IC_CBR;
    else                                              c = IC_OTHER;
    return c;
  endfunction

endpackage

// File: rtl/instr_regdecode.sv
// Combinational register-usage decoder for one LEGv8 instruction.
//   instr   : 32-bit instruction word
//   writes  : instruction writes rd (never set for XZR)
//   rd      : destination field [4:0]
//   rn_used : first source read (never set for XZR)
//   rn      : first source field [9:5]
//   rm_used : second source read (never set for XZR)
//   rm      : second source ([20:16] for R-type, [4:0] for STUR/CBZ/CBNZ)
module instr_regdecode
  import legv8_pkg::*;
(
  input  logic [31:0] instr,
  output logic        writes,
  output logic [4:0]  rd,
  output logic        rn_used,
  output logic [4:0]  rn,
  output logic        rm_used,
  output logic [4:0]  rm
);

  iclass_e cls;
  assign cls = classify(instr);

  always_comb begin
    writes  = 1'b0;
    rn_used = 1'b0;
    rm_used = 1'b0;
    rd      = instr[4:0];
    rn      = instr[9:5];
    rm      = instr[20:16];
    case (cls)
      IC_RTYPE: begin writes = 1'b1; rn_used = 1'b1; rm_used = 1'b1; end
      IC_IMM,
      IC_LOAD:  begin writes = 1'b1; rn_used = 1'b1; end
      // store data and branch condition register both sit in [4:0]
      IC_STORE: begin rn_used = 1'b1; rm_used = 1'b1; rm = instr[4:0]; end
      IC_CBR:   begin rm_used = 1'b1; rm = instr[4:0]; end
      default:  ;
    endcase
    // XZR is hardwired zero: never a producer, never a real dependency
    if (rd == XZR) writes  = 1'b0;
    if (rn == XZR) rn_used = 1'b0;
    if (rm == XZR) rm_used = 1'b0;
  end

endmodule

// File: rtl/fetch_scheduler.sv
// Instruction-fetch sequencer for the LEGv8 pipeline.
// Owns the PC, addresses the combinational instruction ROM, and issues one
// slot per advancing cycle to decode. A small scoreboard of recently issued
// destination registers blocks RAW hazards by issuing NOP bubbles instead.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : pulse, leaves IDLE and fetches from PC 0
//   imem_addr / imem_q  : ROM word address (pc[7:2]) and same-cycle data
//   id_ready            : decode accepts; low freezes the fetch stage
//   if_valid/instr/pc   : registered issue slot
//   br_taken/br_target  : redirect from MEM, highest priority
//   done                : program ran off the end of the ROM
//   bubble_cnt          : saturating count of hazard bubbles
module fetch_scheduler
  import legv8_pkg::*;
#(
  parameter int ROM_WORDS = 23,
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [5:0]       imem_addr,
  input  logic [31:0]      imem_q,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [63:0]      if_pc,
  input  logic             br_taken,
  input  logic [63:0]      br_target,
  output logic             done,
  output logic [CNT_W-1:0] bubble_cnt
);

  fsm_e                      state, state_nxt;
  act_e                      act;
  logic [63:0]               pc;
  sb_entry_t [HAZ_DEPTH-1:0] sb;     // sb[0] is the most recent slot
  sb_entry_t                 sb_in;
  logic                      in_range, hazard;
  logic                      dec_writes, dec_rn_used, dec_rm_used;
  logic [4:0]                dec_rd, dec_rn, dec_rm;

  assign imem_addr = pc[7:2];
  assign in_range  = pc[63:2] < 62'(ROM_WORDS);
  assign done      = (state == DONE);

  instr_regdecode u_dec (
    .instr   (imem_q),
    .writes  (dec_writes),
    .rd      (dec_rd),
    .rn_used (dec_rn_used),
    .rn      (dec_rn),
    .rm_used (dec_rm_used),
    .rm      (dec_rm)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      if (sb[i].vld && ((dec_rn_used && sb[i].rd == dec_rn) ||
                        (dec_rm_used && sb[i].rd == dec_rm)))
        hazard = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. The halt is only taken once decode has accepted the last
  // slot, so a stalled final instruction is never dropped.
  always_comb begin
    state_nxt = state;
    if (br_taken) state_nxt = RUN;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (id_ready && !in_range) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  // Per-cycle action
  always_comb begin
    act = A_IDLE;
    if (br_taken)            act = A_REDIR;
    else if (state == RUN) begin
      if (!id_ready)         act = A_HOLD;
      else if (!in_range)    act = A_IDLE;
      else if (hazard)       act = A_BUBBLE;
      else                   act = A_ISSUE;
    end
  end

  assign sb_in = (act == A_ISSUE) ? '{vld: dec_writes, rd: dec_rd} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
      bubble_cnt <= '0;
      sb         <= '0;
    end else begin
      if (act != A_HOLD) sb <= {sb[HAZ_DEPTH-2:0], sb_in};
      case (act)
        A_IDLE: begin
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
          if (state == IDLE && start) pc <= '0;
        end
        A_REDIR: begin
          // scoreboard keeps ageing: older writers are still in flight
          pc       <= br_target;
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
          if_pc    <= pc;
        end
        A_BUBBLE: begin
          if_valid <= 1'b1;
          if_instr <= NOP_INSTR;
          if_pc    <= pc;
          if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
        end
        A_ISSUE: begin
          if_valid <= 1'b1;
          if_instr <= imem_q;
          if_pc    <= pc;
          pc       <= pc + 64'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_scheduler.sv
// Self-checking bench for fetch_scheduler: a reference model predicts the
// registered outputs for every clock edge and queues them; a monitor pops
// and compares after each edge. Directed programs plus randomized runs.
module tb_fetch_scheduler;
  localparam int ROM_WORDS = 23;
  localparam int CNT_W     = 16;
  localparam logic [31:0] NOP = 32'hd503201f;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, id_ready = 1'b0, br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        if_valid, done;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [CNT_W-1:0] bubble_cnt;
  logic [31:0] rom [64];

  assign imem_q = rom[imem_addr];
  always #5 clk = ~clk;

  fetch_scheduler #(.ROM_WORDS(ROM_WORDS), .HAZ_DEPTH(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
    .imem_q(imem_q), .id_ready(id_ready), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .br_taken(br_taken),
    .br_target(br_target), .done(done), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    bit          valid;
    bit          chk_pc;
    logic [31:0] instr;
    logic [63:0] pc;
    bit          done;
    int          bub;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;

  // Reference model: mode 0 idle, 1 running, 2 finished
  int              m_mode = 0;
  longint unsigned m_pc = 0, m_ipc = 0;
  bit              m_valid = 0;
  logic [31:0]     m_instr = NOP;
  int              m_bub = 0;
  int              m_recent[$] = {-1, -1, -1};  // dest regs of the last 3 slots

  function automatic void regs_of(input logic [31:0] w, output int dst,
                                  output int s0, output int s1);
    dst = -1; s0 = -1; s1 = -1;
    if (w[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550}) begin
      dst = int'(w[4:0]); s0 = int'(w[9:5]); s1 = int'(w[20:16]);
    end else if (w[31:22] inside {10'h244, 10'h344} || w[31:21] == 11'h7C2) begin
      dst = int'(w[4:0]); s0 = int'(w[9:5]);
    end else if (w[31:21] == 11'h7C0) begin
      s0 = int'(w[9:5]); s1 = int'(w[4:0]);
    end else if (w[31:24] inside {8'hB4, 8'hB5}) begin
      s1 = int'(w[4:0]);
    end
    if (dst == 31) dst = -1;
    if (s0 == 31)  s0 = -1;
    if (s1 == 31)  s1 = -1;
  endfunction

  function automatic void age(input int d);
    m_recent.push_front(d);
    void'(m_recent.pop_back());
  endfunction

  function automatic void model_step(input bit rst, st, rdy, br, input logic [63:0] tgt);
    exp_t e;
    int dst, s0, s1;
    bit haz;
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_instr = NOP; m_ipc = 0; m_bub = 0;
      m_recent = {-1, -1, -1};
    end else if (br) begin
      m_pc = tgt; m_mode = 1; m_valid = 0; m_instr = NOP; age(-1);
    end else if (m_mode != 1) begin
      m_valid = 0; m_instr = NOP; age(-1);
      if (m_mode == 0 && st) begin m_mode = 1; m_pc = 0; end
    end else if (rdy) begin
      if (m_pc / 4 >= ROM_WORDS) begin
        m_mode = 2; m_valid = 0; m_instr = NOP; age(-1);
      end else begin
        w = rom[m_pc / 4];
        regs_of(w, dst, s0, s1);
        haz = 0;
        foreach (m_recent[i])
          if (m_recent[i] >= 0 && (m_recent[i] == s0 || m_recent[i] == s1)) haz = 1;
        m_valid = 1; m_ipc = m_pc;
        if (haz) begin
          m_instr = NOP; age(-1);
          if (m_bub < 65535) m_bub++;
        end else begin
          m_instr = w; m_pc = m_pc + 4; age(dst);
        end
      end
    end
    e.valid = m_valid; e.chk_pc = m_valid || rst; e.instr = m_instr;
    e.pc = m_ipc; e.done = (m_mode == 2); e.bub = m_bub;
    exp_q.push_back(e);
  endfunction

  // Monitor: one queued expectation per clock edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin : mon
      exp_t e;
      bit bad;
      e = exp_q.pop_front();
      bad = (if_valid !== e.valid) || (if_instr !== e.instr) || (done !== e.done) ||
            (int'(bubble_cnt) != e.bub) || (e.chk_pc && if_pc !== e.pc);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL slot t=%0t got v=%0b i=%h pc=%h done=%0b bub=%0d want v=%0b i=%h pc=%h done=%0b bub=%0d",
                 $time, if_valid, if_instr, if_pc, done, bubble_cnt,
                 e.valid, e.instr, e.pc, e.done, e.bub);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic cycle(input bit rst, st, rdy, br, input logic [63:0] tgt);
    reset = rst; start = st; id_ready = rdy; br_taken = br; br_target = tgt;
    model_step(rst, st, rdy, br, tgt);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] prog[$]);
    for (int i = 0; i < 64; i++) rom[i] = NOP;
    foreach (prog[i]) rom[i] = prog[i];
  endtask

  task automatic boot(input logic [31:0] prog[$]);
    cycle(1, 0, 1, 0, 0);
    load(prog);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
  endtask

  task automatic run_to_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin cycle(0, 0, 1, 0, 0); n++; end
    chk(name, longint'(done), 1);
  endtask

  function automatic logic [4:0] rreg();
    logic [4:0] r;
    r = ($urandom_range(0, 5) == 5) ? 5'd31 : 5'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    case ($urandom_range(0, 7))
      0: w = {11'h458, rreg(), 6'd0, rreg(), rreg()};
      1: w = {11'h658, rreg(), 6'd0, rreg(), rreg()};
      2: w = {11'h550, rreg(), 6'd0, rreg(), rreg()};
      3: w = {10'h344, 12'($urandom), rreg(), rreg()};
      4: w = {11'h7C2, 9'($urandom), 2'b00, rreg(), rreg()};
      5: w = {11'h7C0, 9'($urandom), 2'b00, rreg(), rreg()};
      6: w = {8'hB4 | 8'($urandom_range(0, 1)), 19'($urandom), rreg()};
      default: w = ($urandom_range(0, 1) == 0) ? NOP : {6'b000101, 26'($urandom)};
    endcase
    return w;
  endfunction

  initial begin : stim
    logic [31:0] h_instr;
    logic [63:0] h_pc;
    logic [5:0]  h_addr;
    int          h_bub;

    // Reset values
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_valid", longint'(if_valid), 0);
    chk("reset_instr", longint'(if_instr), longint'(NOP));
    chk("reset_addr", longint'(imem_addr), 0);

    // Writer X0 then ADDI reading X0: three bubbles
    boot({32'h8b1f03e0, 32'h91002001});
    run_to_done("p1_done", 100);
    chk("p1_bubbles", longint'(bubble_cnt), 3);
    chk("p1_valid_done", longint'(if_valid), 0);

    // X1 written then read: 3 bubbles; with two hand NOPs: 1 bubble
    boot({32'h8b000001, 32'h8b010021});
    run_to_done("p2_done", 100);
    chk("p2_bubbles", longint'(bubble_cnt), 3);
    boot({32'h8b000001, NOP, NOP, 32'h8b010021});
    run_to_done("p2b_done", 100);
    chk("p2b_bubbles", longint'(bubble_cnt), 1);

    // XZR producer never blocks a reader of XZR
    boot({32'h8b1f03ff, 32'h8b1f03e0});
    run_to_done("p3_done", 100);
    chk("p3_bubbles", longint'(bubble_cnt), 0);

    // Stall for 5 cycles mid-program
    boot({32'h8b1f03e0, 32'h91002001, 32'h8b000001, 32'h8b010021});
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    h_instr = if_instr; h_pc = if_pc; h_addr = imem_addr; h_bub = int'(bubble_cnt);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    chk("hold_instr", longint'(if_instr), longint'(h_instr));
    chk("hold_pc", longint'(if_pc), longint'(h_pc));
    chk("hold_addr", longint'(imem_addr), longint'(h_addr));
    chk("hold_bub", longint'(bubble_cnt), longint'(h_bub));
    run_to_done("p4_done", 100);
    chk("p4_bubbles", longint'(bubble_cnt), 6);

    // Branch while a hazard is pending; scoreboard still blocks at target
    begin : p5
      logic [31:0] p[$];
      p = {32'h8b1f03e0, 32'h91002001};
      for (int i = 2; i < 16; i++) p.push_back(NOP);
      p.push_back(32'h91002001);
      boot(p);
    end
    cycle(0, 0, 1, 0, 0);                 // issue writer of X0
    cycle(0, 0, 1, 1, 64'h40);            // hazard pending, redirect wins
    chk("br_valid", longint'(if_valid), 0);
    chk("br_addr", longint'(imem_addr), 16);
    run_to_done("p5_done", 100);
    chk("p5_bubbles", longint'(bubble_cnt), 2);

    // Restart from DONE via branch, then reset mid-run
    cycle(0, 0, 1, 1, 0);
    chk("restart_done", longint'(done), 0);
    cycle(0, 0, 1, 0, 0);
    chk("restart_instr", longint'(if_instr), 32'h8b1f03e0);
    chk("restart_valid", longint'(if_valid), 1);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    chk("mid_reset_valid", longint'(if_valid), 0);
    chk("mid_reset_pc", longint'(if_pc), 0);
    chk("mid_reset_bub", longint'(bubble_cnt), 0);
    chk("mid_reset_done", longint'(done), 0);

    // Randomized programs and control
    for (int r = 0; r < 4; r++) begin
      logic [31:0] p[$];
      p = {};
      for (int i = 0; i < ROM_WORDS; i++) p.push_back(rand_instr());
      boot(p);
      for (int i = ROM_WORDS; i < 64; i++) rom[i] = $urandom;
      for (int c = 0; c < 300; c++) begin
        logic [63:0] tgt;
        tgt = ($urandom_range(0, 9) == 0) ? 64'hffff_ffff_ffff_fffc
                                          : 64'($urandom_range(0, 111));
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, tgt);
      end
    end

    @(posedge clk); #4;
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
